// File: rtl/vga_wb_regs.sv
// vga_wb_regs: Wishbone register front-end for the vga core.
// Holds double-buffered base/font addresses, a palette FIFO drained over a
// toggle req/ack handshake, mode selection, and a vblank interrupt.
//
// Palette drain FSM
//   state   | meaning
//   IDLE    | no palette entry in flight; pop head when FIFO non-empty and req==ack
//   WAIT    | entry presented to vga core; waiting for ack to match req
module vga_wb_regs #(
   parameter int WB_DW     = 8,
   parameter int PAL_DEPTH = 8,
   parameter int RAM_AW    = 18
) (
   input  logic              I_wb_clk,
   input  logic              I_reset_n,
   input  logic [3:0]        I_wb_adr,
   input  logic [WB_DW-1:0]  I_wb_dat,
   input  logic              I_wb_stb,
   input  logic              I_wb_we,
   output logic              O_wb_ack,
   output logic [WB_DW-1:0]  O_wb_dat,
   output logic [3:0]        O_vga_mode,
   output logic [RAM_AW-1:0] O_base_adr,
   output logic [RAM_AW-1:0] O_font_adr,
   output logic [31:0]       O_palette_update,
   output logic              O_palette_update_req,
   input  logic              I_palette_update_ack,
   input  logic              I_frame_start,
   input  logic [9:0]        I_line,
   input  logic              I_line_visible,
   output logic              O_irq
);

   localparam int PAW = $clog2(PAL_DEPTH);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   localparam logic [1:0] W_BASE = 2'd0;
   localparam logic [1:0] W_FONT = 2'd1;
   localparam logic [1:0] W_PAL  = 2'd2;
   localparam logic [1:0] W_CTRL = 2'd3;

   localparam logic [RAM_AW-1:0] BASE_RST = RAM_AW'(32'h20000);
   localparam logic [RAM_AW-1:0] FONT_RST = RAM_AW'(32'h30000);
   localparam logic [PAW:0]      PTR_ONE  = 1;

   logic              acc;
   logic              wr;
   logic              commit;
   logic [1:0]        word_sel;
   logic [31:0]       wdata;
   logic [31:0]       rd_word;

   logic [RAM_AW-1:0] base_shadow;
   logic [RAM_AW-1:0] font_shadow;
   logic [31:0]       pal_last;
   logic [1:0]        mode;
   logic              irq_en;
   logic              pend;
   logic              ovf;

   logic [31:0]       mem [PAL_DEPTH];
   logic [PAW:0]      wr_ptr;
   logic [PAW:0]      rd_ptr;
   logic              fifo_empty;
   logic              fifo_full;
   logic              push;
   logic              push_ok;
   logic              pop;
   logic [0:0]        state;

   // Side effects only on the first cycle of a strobe (ack still low).
   assign acc      = I_wb_stb & ~O_wb_ack;
   assign wr       = acc & I_wb_we;
   assign word_sel = I_wb_adr[3:2];

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PAW] != rd_ptr[PAW]) &&
                       (wr_ptr[PAW-1:0] == rd_ptr[PAW-1:0]);
   assign pop        = (state == ST_IDLE) && !fifo_empty &&
                       (O_palette_update_req == I_palette_update_ack);
   assign push       = commit && (word_sel == W_PAL);
   // A same-cycle pop frees a slot, so the push is accepted even when full.
   assign push_ok    = push && (!fifo_full || pop);

   assign O_irq = pend & irq_en;

   // Mode code to vga core encoding.
   always_comb begin
      O_vga_mode = 4'h0;
      case (mode)
         2'd0:    O_vga_mode = 4'h0;
         2'd1:    O_vga_mode = 4'h7;
         2'd2:    O_vga_mode = 4'h4;
         default: O_vga_mode = 4'h5;
      endcase
   end

   // Register readback word selected by the word index.
   always_comb begin
      rd_word = '0;
      case (word_sel)
         W_BASE:  rd_word = 32'({base_shadow, 1'b0});
         W_FONT:  rd_word = 32'({font_shadow, 1'b0});
         W_PAL:   rd_word = pal_last;
         default: rd_word = {5'b0, I_line_visible, I_line, 4'b0, fifo_empty,
                             ovf, pend, irq_en, 6'b0, mode};
      endcase
   end

   // Single-cycle acknowledge, one cycle after strobe.
   always_ff @(posedge I_wb_clk) begin
      if (!I_reset_n) O_wb_ack <= 1'b0;
      else            O_wb_ack <= I_wb_stb & ~O_wb_ack;
   end

   generate
      if (WB_DW == 8) begin : g_dw8
         logic [23:0] staging;

         // Byte lanes 0-2 stage; lane 3 commits; reads return the addressed byte.
         always_ff @(posedge I_wb_clk) begin
            if (!I_reset_n) begin
               staging  <= '0;
               O_wb_dat <= '0;
            end else begin
               if (wr) begin
                  case (I_wb_adr[1:0])
                     2'd0:    staging[7:0]   <= I_wb_dat;
                     2'd1:    staging[15:8]  <= I_wb_dat;
                     2'd2:    staging[23:16] <= I_wb_dat;
                     default: ;
                  endcase
               end
               if (acc && !I_wb_we) begin
                  case (I_wb_adr[1:0])
                     2'd0:    O_wb_dat <= rd_word[7:0];
                     2'd1:    O_wb_dat <= rd_word[15:8];
                     2'd2:    O_wb_dat <= rd_word[23:16];
                     default: O_wb_dat <= rd_word[31:24];
                  endcase
               end
            end
         end

         assign wdata  = {I_wb_dat, staging};
         assign commit = wr && (I_wb_adr[1:0] == 2'd3);
      end else begin : g_dw32
         logic unused_lane;
         assign unused_lane = ^I_wb_adr[1:0];

         // Full-word readback; byte lane bits are ignored.
         always_ff @(posedge I_wb_clk) begin
            if (!I_reset_n)            O_wb_dat <= '0;
            else if (acc && !I_wb_we) O_wb_dat <= rd_word;
         end

         assign wdata  = I_wb_dat;
         assign commit = wr;
      end
   endgenerate

   // Register commits, frame-start buffer swap and interrupt pending.
   always_ff @(posedge I_wb_clk) begin
      if (!I_reset_n) begin
         base_shadow <= BASE_RST;
         font_shadow <= FONT_RST;
         O_base_adr  <= BASE_RST;
         O_font_adr  <= FONT_RST;
         pal_last    <= '0;
         mode        <= 2'd0;
         irq_en      <= 1'b0;
         pend        <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         if (commit) begin
            case (word_sel)
               W_BASE: base_shadow <= wdata[RAM_AW:1];
               W_FONT: font_shadow <= wdata[RAM_AW:1];
               W_PAL:  pal_last    <= wdata;
               default: begin
                  mode   <= wdata[1:0];
                  irq_en <= wdata[8];
                  if (wdata[9])  pend <= 1'b0;
                  if (wdata[10]) ovf  <= 1'b0;
               end
            endcase
         end
         // Active takes the pre-commit shadow; pend set wins over W1C.
         if (I_frame_start) begin
            O_base_adr <= base_shadow;
            O_font_adr <= font_shadow;
            pend       <= 1'b1;
         end
         if (push && !push_ok) ovf <= 1'b1;
      end
   end

   // Palette FIFO storage.
   always_ff @(posedge I_wb_clk) begin
      if (I_reset_n && push_ok) mem[wr_ptr[PAW-1:0]] <= wdata;
   end

   // FIFO pointers and palette drain handshake.
   always_ff @(posedge I_wb_clk) begin
      if (!I_reset_n) begin
         wr_ptr               <= '0;
         rd_ptr               <= '0;
         state                <= ST_IDLE;
         O_palette_update_req <= 1'b0;
         O_palette_update     <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  O_palette_update     <= mem[rd_ptr[PAW-1:0]];
                  O_palette_update_req <= ~O_palette_update_req;
                  rd_ptr               <= rd_ptr + PTR_ONE;
                  state                <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (I_palette_update_ack == O_palette_update_req) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_wb_regs.sv
// Testbench for vga_wb_regs: an 8-bit and a 32-bit instance side by side.
module tb_vga_wb_regs;
   localparam int PAL_DEPTH = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [3:0]  adr;
   logic        we;
   logic        fs;
   logic [9:0]  line;
   logic        vis;

   logic        stb8, ack8, req8, pack8, irq8;
   logic [7:0]  dat8, rdat8;
   logic [3:0]  mode8;
   logic [17:0] base8, font8;
   logic [31:0] upd8;

   logic        stb32, ack32, req32, pack32, irq32;
   logic [31:0] dat32, rdat32;
   logic [3:0]  mode32;
   logic [17:0] base32, font32;
   logic [31:0] upd32;

   int errors = 0;
   int checks = 0;

   // Reference model state for the 8-bit instance.
   logic [17:0] m_base_sh, m_base_act, m_font_sh, m_font_act;
   logic [1:0]  m_mode;
   logic        m_irqen, m_pend, m_ovf;
   logic [31:0] m_pal_last;
   logic [31:0] m_q[$];
   logic [3:0]  mode_tab [4] = '{4'h0, 4'h7, 4'h4, 4'h5};

   vga_wb_regs #(.WB_DW(8), .PAL_DEPTH(PAL_DEPTH), .RAM_AW(18)) dut8 (
      .I_wb_clk(clk), .I_reset_n(rst_n), .I_wb_adr(adr), .I_wb_dat(dat8),
      .I_wb_stb(stb8), .I_wb_we(we), .O_wb_ack(ack8), .O_wb_dat(rdat8),
      .O_vga_mode(mode8), .O_base_adr(base8), .O_font_adr(font8),
      .O_palette_update(upd8), .O_palette_update_req(req8),
      .I_palette_update_ack(pack8), .I_frame_start(fs), .I_line(line),
      .I_line_visible(vis), .O_irq(irq8));

   vga_wb_regs #(.WB_DW(32), .PAL_DEPTH(PAL_DEPTH), .RAM_AW(18)) dut32 (
      .I_wb_clk(clk), .I_reset_n(rst_n), .I_wb_adr(adr), .I_wb_dat(dat32),
      .I_wb_stb(stb32), .I_wb_we(we), .O_wb_ack(ack32), .O_wb_dat(rdat32),
      .O_vga_mode(mode32), .O_base_adr(base32), .O_font_adr(font32),
      .O_palette_update(upd32), .O_palette_update_req(req32),
      .I_palette_update_ack(pack32), .I_frame_start(fs), .I_line(line),
      .I_line_visible(vis), .O_irq(irq32));

   function automatic logic [31:0] exp_ctrl(input logic empty);
      return {5'b0, vis, line, 4'b0, empty, m_ovf, m_pend, m_irqen, 6'b0, m_mode};
   endfunction

   // Model effect of a committed word, optionally on a frame_start edge.
   task automatic model_step(input logic [1:0] word, input logic [31:0] v, input logic f);
      if (f) begin m_base_act = m_base_sh; m_font_act = m_font_sh; end
      case (word)
         2'd0: m_base_sh = v[18:1];
         2'd1: m_font_sh = v[18:1];
         2'd2: m_pal_last = v;
         default: begin
            m_mode  = v[1:0];
            m_irqen = v[8];
            if (v[9])  m_pend = 1'b0;
            if (v[10]) m_ovf  = 1'b0;
         end
      endcase
      if (f) m_pend = 1'b1;
   endtask

   task automatic bus8(input logic w, input logic [1:0] word, input logic [1:0] lane,
                       input logic [7:0] d, input logic f, output logic [7:0] q);
      @(negedge clk);
      stb8 = 1'b1; we = w; adr = {word, lane}; dat8 = d; fs = f;
      @(negedge clk);
      q = rdat8;
      checks++;
      if (ack8 !== 1'b1) begin errors++; $display("FAIL bus8_ack got=%b exp=1", ack8); end
      stb8 = 1'b0; we = 1'b0; fs = 1'b0;
   endtask

   task automatic write8(input logic [1:0] word, input logic [31:0] v, input logic f);
      logic [7:0] q;
      bus8(1'b1, word, 2'd0, v[7:0],   1'b0, q);
      bus8(1'b1, word, 2'd1, v[15:8],  1'b0, q);
      bus8(1'b1, word, 2'd2, v[23:16], 1'b0, q);
      bus8(1'b1, word, 2'd3, v[31:24], f,    q);
      model_step(word, v, f);
   endtask

   task automatic read8(input logic [1:0] word, output logic [31:0] v);
      logic [7:0] q;
      for (int l = 0; l < 4; l++) begin
         bus8(1'b0, word, 2'(l), 8'h00, 1'b0, q);
         v[8*l +: 8] = q;
      end
   endtask

   task automatic frame_pulse();
      @(negedge clk); fs = 1'b1;
      @(negedge clk); fs = 1'b0;
      m_base_act = m_base_sh; m_font_act = m_font_sh; m_pend = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      rst_n = 1'b0; stb8 = 1'b1; stb32 = 1'b1; we = 1'b0; adr = 4'b1100;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (ack8 !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", ack8); end
      checks++; if (base8 !== 18'h20000) begin errors++; $display("FAIL rst_base got=%h exp=20000", base8); end
      checks++; if (font8 !== 18'h30000) begin errors++; $display("FAIL rst_font got=%h exp=30000", font8); end
      checks++; if ({req8, irq8, mode8} !== 6'b0) begin errors++; $display("FAIL rst_outs got=%b exp=0", {req8, irq8, mode8}); end
      checks++; if (base32 !== 18'h20000) begin errors++; $display("FAIL rst_base32 got=%h exp=20000", base32); end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (ack8 !== logic'(i % 2 == 0)) begin errors++; $display("FAIL rst_ack_seq8 i=%0d got=%b", i, ack8); end
         checks++;
         if (ack32 !== logic'(i % 2 == 0)) begin errors++; $display("FAIL rst_ack_seq32 i=%0d got=%b", i, ack32); end
         if (i == 0) begin
            checks++; if (rdat8 !== 8'h00) begin errors++; $display("FAIL rst_ctrl_lane0 got=%h exp=00", rdat8); end
         end
      end
      stb8 = 1'b0; stb32 = 1'b0;
      @(negedge clk);
      read8(2'd3, v);
      checks++; if (v !== exp_ctrl(1'b1)) begin errors++; $display("FAIL rst_ctrl got=%h exp=%h", v, exp_ctrl(1'b1)); end
   endtask

   task automatic test_base_font();
      logic [31:0] v, r;
      logic [1:0]  wd;
      write8(2'd0, 32'h0006_0000, 1'b0);
      read8(2'd0, r);
      checks++; if (r !== 32'h0006_0000) begin errors++; $display("FAIL base_rd got=%h exp=00060000", r); end
      checks++; if (base8 !== 18'h20000) begin errors++; $display("FAIL base_early got=%h exp=20000", base8); end
      frame_pulse();
      checks++; if (base8 !== 18'h30000) begin errors++; $display("FAIL base_apply got=%h exp=30000", base8); end
      for (int i = 0; i < 6; i++) begin
         v  = $urandom;
         wd = 2'($urandom_range(0, 1));
         write8(wd, v, 1'b0);
         read8(wd, r);
         checks++;
         if (r !== 32'({(wd == 2'd0) ? m_base_sh : m_font_sh, 1'b0}))
            begin errors++; $display("FAIL bf_rd w=%0d got=%h wr=%h", wd, r, v); end
         frame_pulse();
         checks++;
         if ({base8, font8} !== {m_base_act, m_font_act})
            begin errors++; $display("FAIL bf_act got=%h/%h exp=%h/%h", base8, font8, m_base_act, m_font_act); end
      end
   endtask

   task automatic test_same_edge();
      logic [17:0] old_sh;
      logic [31:0] v;
      old_sh = m_base_sh;
      v = {$urandom} & 32'h0007_FFFE;
      if (v[18:1] == old_sh) v = v ^ 32'h0000_0100;
      write8(2'd0, v, 1'b1);
      checks++; if (base8 !== old_sh) begin errors++; $display("FAIL same_edge_old got=%h exp=%h", base8, old_sh); end
      frame_pulse();
      checks++; if (base8 !== v[18:1]) begin errors++; $display("FAIL same_edge_new got=%h exp=%h", base8, v[18:1]); end
   endtask

   task automatic test_palette();
      logic [31:0] w, r, inflight, exp;
      bit busy, got;
      busy = 0;
      m_q.delete();
      for (int i = 0; i < PAL_DEPTH + 2; i++) begin
         w = $urandom;
         write8(2'd2, w, 1'b0);
         if (!busy) begin inflight = w; busy = 1; end
         else if (m_q.size() < PAL_DEPTH) m_q.push_back(w);
         else m_ovf = 1'b1;
      end
      checks++; if (req8 === pack8) begin errors++; $display("FAIL pal_req got=%b ack=%b", req8, pack8); end
      checks++; if (upd8 !== inflight) begin errors++; $display("FAIL pal_first got=%h exp=%h", upd8, inflight); end
      read8(2'd3, r);
      checks++; if (r !== exp_ctrl(1'b0)) begin errors++; $display("FAIL pal_ctrl_ovf got=%h exp=%h", r, exp_ctrl(1'b0)); end
      read8(2'd2, r);
      checks++; if (r !== m_pal_last) begin errors++; $display("FAIL pal_rd got=%h exp=%h", r, m_pal_last); end
      while (busy) begin
         @(negedge clk); pack8 = req8;
         if (m_q.size() > 0) begin
            exp = m_q.pop_front();
            got = 0;
            for (int c = 0; c < 10 && !got; c++) begin
               @(negedge clk);
               if (req8 !== pack8) got = 1;
            end
            checks++; if (!got) begin errors++; $display("FAIL pal_drain_timeout got=%b exp=%b", req8, ~pack8); end
            checks++; if (upd8 !== exp) begin errors++; $display("FAIL pal_order got=%h exp=%h", upd8, exp); end
         end else begin
            busy = 0;
            repeat (3) @(negedge clk);
            checks++; if (req8 !== pack8) begin errors++; $display("FAIL pal_spurious got=%b exp=%b", req8, pack8); end
         end
      end
      line = 10'($urandom); vis = 1'b1;
      read8(2'd3, r);
      checks++; if (r !== exp_ctrl(1'b1)) begin errors++; $display("FAIL pal_empty got=%h exp=%h", r, exp_ctrl(1'b1)); end
      write8(2'd3, 32'h0000_0400, 1'b0);
      read8(2'd3, r);
      checks++; if (r !== exp_ctrl(1'b1)) begin errors++; $display("FAIL ovf_clr got=%h exp=%h", r, exp_ctrl(1'b1)); end
   endtask

   task automatic test_irq_mode();
      logic [31:0] r;
      logic [1:0]  m;
      write8(2'd3, 32'h0000_0300, 1'b0);
      checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL irq_clr0 got=%b exp=0", irq8); end
      frame_pulse();
      checks++; if (irq8 !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", irq8); end
      write8(2'd3, 32'h0000_0300, 1'b0);
      checks++; if (irq8 !== 1'b0) begin errors++; $display("FAIL irq_w1c got=%b exp=0", irq8); end
      write8(2'd3, 32'h0000_0300, 1'b1);
      checks++; if (irq8 !== 1'b1) begin errors++; $display("FAIL irq_set_wins got=%b exp=1", irq8); end
      for (int i = 0; i < 6; i++) begin
         m = (i < 4) ? 2'(i) : 2'($urandom);
         write8(2'd3, {21'b0, 1'b0, 1'b0, ($urandom % 2 == 1), 6'b0, m}, 1'b0);
         checks++;
         if (mode8 !== mode_tab[m]) begin errors++; $display("FAIL vga_mode m=%0d got=%h exp=%h", m, mode8, mode_tab[m]); end
         checks++; if (irq8 !== (m_pend & m_irqen)) begin errors++; $display("FAIL irq_level got=%b exp=%b", irq8, m_pend & m_irqen); end
         line = 10'($urandom); vis = 1'($urandom);
         read8(2'd3, r);
         checks++; if (r !== exp_ctrl(1'b1)) begin errors++; $display("FAIL ctrl_rd got=%h exp=%h", r, exp_ctrl(1'b1)); end
      end
   endtask

   task automatic test_dw32();
      logic [31:0] v;
      @(negedge clk);
      stb32 = 1'b1; we = 1'b1; adr = {2'd2, 2'($urandom)}; dat32 = 32'h0AFF_8000;
      @(negedge clk);
      checks++; if (ack32 !== 1'b1) begin errors++; $display("FAIL dw32_ack got=%b exp=1", ack32); end
      checks++; if (req32 !== 1'b0) begin errors++; $display("FAIL dw32_req_early got=%b exp=0", req32); end
      stb32 = 1'b0; we = 1'b0;
      @(negedge clk);
      checks++; if (req32 !== 1'b1) begin errors++; $display("FAIL dw32_req got=%b exp=1", req32); end
      checks++; if (upd32 !== 32'h0AFF_8000) begin errors++; $display("FAIL dw32_upd got=%h exp=0aff8000", upd32); end
      pack32 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         v = $urandom;
         @(negedge clk);
         stb32 = 1'b1; we = 1'b1; adr = {2'd0, 2'($urandom)}; dat32 = v;
         @(negedge clk); stb32 = 1'b0; we = 1'b0;
         @(negedge clk);
         stb32 = 1'b1; adr = {2'd0, 2'($urandom)};
         @(negedge clk); stb32 = 1'b0;
         checks++; if (rdat32 !== {13'b0, v[18:1], 1'b0}) begin errors++; $display("FAIL dw32_base_rd got=%h exp=%h", rdat32, {13'b0, v[18:1], 1'b0}); end
         frame_pulse();
         checks++; if (base32 !== v[18:1]) begin errors++; $display("FAIL dw32_base_act got=%h exp=%h", base32, v[18:1]); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; adr = '0; we = 1'b0; fs = 1'b0; line = '0; vis = 1'b0;
      stb8 = 1'b0; dat8 = '0; pack8 = 1'b0;
      stb32 = 1'b0; dat32 = '0; pack32 = 1'b0;
      m_base_sh = 18'h20000; m_base_act = 18'h20000;
      m_font_sh = 18'h30000; m_font_act = 18'h30000;
      m_mode = 2'd0; m_irqen = 1'b0; m_pend = 1'b0; m_ovf = 1'b0; m_pal_last = '0;
      test_reset();
      test_base_font();
      test_same_edge();
      test_palette();
      test_irq_mode();
      test_dw32();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
